muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 Start  in  1  request new division; sampled only in IDLE or DONE.
REQ-004 Op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with accepted Start.
REQ-005 Dividend  in  32  rs1 operand; sampled with accepted Start.
REQ-006 Divisor  in  32  rs2 operand; sampled with accepted Start.
REQ-007 Flush  in  1  abort any in-flight operation.
REQ-008 Stall  out  1  holds the pipeline while an operation is in flight.
REQ-009 Busy  out  1  high in PREP, ITER, FIX.
REQ-010 Done  out  1  one-cycle pulse; Result valid in that cycle.
REQ-011 Result  out  32  quotient or remainder per latched Op.

Function
REQ-012 States SHALL be IDLE, PREP, ITER, FIX, DONE; encoding is free.
REQ-013 Accepted start = Start & ~Flush while state is IDLE or DONE; it SHALL latch Op, Dividend and Divisor and enter PREP.
REQ-014 Start while Busy SHALL be ignored, with no latch and no state change.
REQ-015 PREP SHALL record operand signs (signed ops only), convert operands to magnitudes and clear the partial remainder and the 6-bit iteration counter.
REQ-016 In PREP, Divisor==0 SHALL go directly to DONE with quotient=32'hFFFFFFFF and remainder=latched Dividend.
REQ-017 In PREP, signed op with Dividend==32'h80000000 and Divisor==32'hFFFFFFFF SHALL go directly to DONE with quotient=32'h80000000 and remainder=0.
REQ-018 ITER SHALL perform one restoring radix-2 step per cycle, using a 33-bit subtract for the trial remainder, for exactly 32 cycles, then go to FIX.
REQ-019 FIX SHALL negate the quotient if the sign of the dividend XOR the sign of the divisor is 1, and negate the remainder if the dividend was negative (signed ops only), then go to DONE.
REQ-020 DONE SHALL last one cycle with Done=1, then go to PREP if a start is accepted, else to IDLE.
REQ-021 Result SHALL select the quotient for Op[1]=0 and the remainder for Op[1]=1.
REQ-022 Result SHALL hold its value from DONE until the next DONE.
REQ-023 Latency: with the start sampled at edge E, Done SHALL be high in the cycle after edge E+34 (normal path) or edge E+1 (REQ-016/017 paths).
REQ-024 Stall SHALL equal (Start & ~Flush & state in {IDLE, DONE}) | Busy, combinationally.
REQ-025 Stall SHALL be 0 in the DONE cycle unless a new start is accepted.
REQ-026 Flush SHALL force IDLE at the next edge from any state, with no Done pulse and Result unchanged.
REQ-027 Flush takes priority over a simultaneous Start.
REQ-028 Unsigned ops SHALL treat operands as magnitudes with no fix-up in FIX.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear Done, Busy, Result, the counter and all operand registers to 0, including mid-operation.
REQ-030 Stall SHALL equal 0 during reset, regardless of Start.
REQ-031 The first edge after rst_n deasserts SHALL sample Start normally.

Verification
REQ-032 DIV 100/7 and REM 100/7 -> Result 14 and 2; Done exactly 34 edges after the start edge; Stall high throughout.
REQ-033 DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 32'hFFFFFFF9/2 -> 32'h7FFFFFFC.
REQ-034 DIVU 5/0 -> 32'hFFFFFFFF; REMU 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000; REM 32'h80000000/-1 -> 0; each Done at latency 2.
REQ-035 Back-to-back starts: the second Start, asserted in the first op's DONE cycle, is accepted with no idle gap; each op produces one Done. A Start asserted mid-ITER is ignored.
REQ-036 Flush at ITER cycle 10 -> IDLE next edge, no Done, prior Result retained. rst_n low at ITER cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequential 32-bit divider (DIV/DIVU/REM/REMU) using restoring radix-2 division.
// Stall/Busy/Done handshake with the pipeline; Flush aborts, async active-low reset clears everything.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [2:0]  dbgState
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} stateT;

    stateT       state;
    stateT       stateNext;
    logic [1:0]  opReg;
    logic [31:0] dividendReg;
    logic [31:0] divisorReg;
    logic [31:0] quoReg;
    logic [31:0] remReg;
    logic [31:0] divReg;
    logic [5:0]  count;
    logic        negQ;
    logic        negR;

    logic        accept;
    logic        signedOp;
    logic        divZero;
    logic        overflow;
    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quoFix;
    logic [31:0] remFix;

    // Handshake: a start is accepted only in IDLE/DONE when not flushed; Stall
    // covers that acceptance cycle plus every busy cycle, and is forced low in reset.
    assign accept   = Start & ~Flush & ((state == IDLE) | (state == DONE));
    assign Busy     = (state == PREP) | (state == ITER) | (state == FIX);
    assign Done     = (state == DONE);
    assign Stall    = rst_n & (accept | Busy);
    assign dbgState = state;

    assign signedOp    = ~opReg[0];
    assign divZero     = (divisorReg == 32'd0);
    assign overflow    = signedOp & (dividendReg == 32'h8000_0000) & (divisorReg == 32'hFFFF_FFFF);
    assign dividendMag = (signedOp & dividendReg[31]) ? (~dividendReg + 32'd1) : dividendReg;
    assign divisorMag  = (signedOp & divisorReg[31])  ? (~divisorReg + 32'd1)  : divisorReg;

    // Restoring step: shift the next dividend bit into the remainder and try the subtract.
    assign shifted = {remReg, quoReg[31]};
    assign diff    = shifted - {1'b0, divReg};
    assign quoFix  = negQ ? (~quoReg + 32'd1) : quoReg;
    assign remFix  = negR ? (~remReg + 32'd1) : remReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (Flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) stateNext = PREP;
                PREP:    stateNext = (divZero | overflow) ? DONE : ITER;
                ITER:    if (count == 6'd31) stateNext = FIX;
                FIX:     stateNext = DONE;
                DONE:    stateNext = accept ? PREP : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg       <= 2'd0;
            dividendReg <= 32'd0;
            divisorReg  <= 32'd0;
            quoReg      <= 32'd0;
            remReg      <= 32'd0;
            divReg      <= 32'd0;
            count       <= 6'd0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            Result      <= 32'd0;
        end else begin
            if (accept) begin
                opReg       <= Op;
                dividendReg <= Dividend;
                divisorReg  <= Divisor;
            end
            if (!Flush) begin
                case (state)
                    PREP: begin
                        negQ   <= signedOp & (dividendReg[31] ^ divisorReg[31]);
                        negR   <= signedOp & dividendReg[31];
                        quoReg <= dividendMag;
                        divReg <= divisorMag;
                        remReg <= 32'd0;
                        count  <= 6'd0;
                        if (divZero) begin
                            Result <= opReg[1] ? dividendReg : 32'hFFFF_FFFF;
                        end else if (overflow) begin
                            Result <= opReg[1] ? 32'd0 : 32'h8000_0000;
                        end
                    end
                    ITER: begin
                        if (!diff[32]) begin
                            remReg <= diff[31:0];
                            quoReg <= {quoReg[30:0], 1'b1};
                        end else begin
                            remReg <= shifted[31:0];
                            quoReg <= {quoReg[30:0], 1'b0};
                        end
                        count <= count + 6'd1;
                    end
                    FIX: begin
                        Result <= opReg[1] ? remFix : quoFix;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// operations, checked by a queue-based scoreboard against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        Flush;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [2:0]  dbgState;

    int          checks = 0;
    int          fails = 0;
    int          cycleCnt = 0;
    int          lastExpDone = 0;
    logic [31:0] lastResult = 32'd0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] monExp;
    int          monLat;

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .Dividend(Dividend),
        .Divisor(Divisor), .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done),
        .Result(Result), .dbgState(dbgState)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // reference model: plain 64-bit arithmetic with the two architectural special cases
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end else begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? 32'(r) : 32'(q);
    endfunction

    function automatic bit isFast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (rst_n && Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 with Result %h, required no Done", Result);
            end else begin
                monExp = exp_q.pop_front();
                monLat = lat_q.pop_front();
                check("result", Result, monExp);
                check("done_cycle", cycleCnt, monLat);
            end
            check("stall_in_done", Stall, Start & ~Flush);
        end
    end

    // driver tasks
    task automatic issueOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit doPush);
        Start       = 1'b1;
        Op          = op;
        Dividend    = a;
        Divisor     = b;
        lastExpDone = cycleCnt + 1 + (isFast(op, a, b) ? 1 : 34);
        if (doPush) begin
            exp_q.push_back(exp);
            lat_q.push_back(lastExpDone);
        end
    endtask

    task automatic endStart();
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic waitDone(input int expDone);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (cycleCnt < expDone) begin
                check("busy_inflight", Busy, 1);
                check("stall_inflight", Stall, 1);
                check("no_early_done", Done, 0);
                @(negedge clk);
            end else begin
                check("done_at_latency", Done, 1);
                check("busy_in_done", Busy, 0);
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL wait_timeout: got no Done by cycle %0d, required by %0d", cycleCnt, expDone);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        issueOp(op, a, b, exp, 1'b1);
        endStart();
        waitDone(lastExpDone);
        lastResult = exp;
    endtask

    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    int          expDone1;

    initial begin
        rst_n = 1'b0; Start = 1'b1; Flush = 1'b0; Op = 2'd0; Dividend = 32'd0; Divisor = 32'd0;
        #1;
        check("reset_stall", Stall, 0);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_result", Result, 32'd0);
        repeat (3) @(negedge clk);
        Start = 1'b0;
        rst_n = 1'b1;

        // basic and signed corners
        runOp(2'b00, 32'd100, 32'd7, 32'd14);
        runOp(2'b10, 32'd100, 32'd7, 32'd2);
        runOp(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runOp(2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        runOp(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runOp(2'b11, 32'd5, 32'd0, 32'd5);
        runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // back-to-back: second start in the DONE cycle of the first
        @(negedge clk);
        issueOp(2'b00, 32'd100, 32'd7, 32'd14, 1'b1);
        endStart();
        waitDone(lastExpDone);
        issueOp(2'b11, 32'd50, 32'd6, 32'd2, 1'b1);
        #1;
        check("stall_b2b", Stall, 1);
        endStart();
        waitDone(lastExpDone);
        lastResult = 32'd2;

        // start mid-ITER is ignored
        @(negedge clk);
        issueOp(2'b01, 32'd1000, 32'd3, 32'd333, 1'b1);
        expDone1 = lastExpDone;
        endStart();
        repeat (8) @(negedge clk);
        Start = 1'b1; Op = 2'b11; Dividend = 32'hFFFF; Divisor = 32'd0;
        endStart();
        waitDone(expDone1);
        lastResult = 32'd333;

        // flush at ITER cycle 10, with a simultaneous start
        @(negedge clk);
        issueOp(2'b00, 32'd12345, 32'd11, 32'd0, 1'b0);
        endStart();
        repeat (10) @(negedge clk);
        Flush = 1'b1; Start = 1'b1;
        @(negedge clk);
        Flush = 1'b0; Start = 1'b0;
        #1;
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        check("flush_stall", Stall, 0);
        check("flush_result_kept", Result, lastResult);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            check("flush_no_done", Done, 0);
        end

        // reset at ITER cycle 20
        @(negedge clk);
        issueOp(2'b00, 32'd999, 32'd4, 32'd0, 1'b0);
        endStart();
        repeat (20) @(negedge clk);
        rst_n = 1'b0; Start = 1'b1;
        #1;
        check("midreset_done", Done, 0);
        check("midreset_busy", Busy, 0);
        check("midreset_stall", Stall, 0);
        check("midreset_result", Result, 32'd0);
        lastResult = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        issueOp(2'b01, 32'd1000, 32'd10, 32'd100, 1'b1);
        endStart();
        waitDone(lastExpDone);
        lastResult = 32'd100;

        // random operations against the model
        for (int n = 0; n < 40; n++) begin
            rOp = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       begin rA = $urandom; rB = 32'd0; end
                1:       begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
                2:       begin rA = 32'($urandom_range(0, 1000)); rB = 32'($urandom_range(1, 20)); end
                3:       begin rA = $urandom; rB = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
                default: begin rA = $urandom; rB = $urandom >> $urandom_range(0, 31); end
            endcase
            runOp(rOp, rA, rB, refModel(rOp, rA, rB));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
